// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command receiver.
//   - default field widths (match the command decoder parameters)
//   - frame width derivation
//   - receiver state encoding
package spi_pkg;

  localparam int CMD_WIDTH_DEF      = 8;
  localparam int DATAWORD_WIDTH_DEF = 16;

  function automatic int frame_width(input int cmd_w, input int data_w);
    return cmd_w + data_w;
  endfunction

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronizer with edge detect for one SPI pin sampled in sys_clk.
//   sys_clk, rst : clock, async active-high reset
//   pin          : raw asynchronous pin
//   sync         : synchronized level (SYNC_STAGES flops)
//   rise, fall   : registered one-cycle edge pulses, one cycle after sync changes
// All flops reset to 0 so a chip select held low through reset never looks
// like a falling edge once reset releases.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_cmd_receiver.sv
// SPI mode-0 slave front end: deserializes {cmd, data} frames clocked by the
// sampled SPI pins and presents each correctly sized frame with a one-cycle
// cmd_valid strobe; wrong-length frames pulse frame_err instead.
//   sys_clk, rst         : system clock, async active-high reset
//   spi_sclk/cs_n/mosi   : raw SPI pins (sampled, never used as clocks)
//   spi_miso             : readback data, 0 unless SPI_READBACK_EN is defined
//   cmd_word, data_word  : fields of the last accepted frame
//   cmd_valid, frame_err : one-cycle strobes, mutually exclusive
// Build option: SPI_READBACK_EN shifts the last accepted frame out on MISO
// during the next frame.
module spi_cmd_receiver
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH      = CMD_WIDTH_DEF,
  parameter int DATAWORD_WIDTH = DATAWORD_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      spi_sclk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [CMD_WIDTH-1:0]      cmd_word,
  output logic [DATAWORD_WIDTH-1:0] data_word,
  output logic                      cmd_valid,
  output logic                      frame_err
);

  localparam int FW    = frame_width(CMD_WIDTH, DATAWORD_WIDTH);
  localparam int CNT_W = $clog2(FW + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);
  // Saturation value sits one above a full frame so overruns never alias.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FW + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .sys_clk(sys_clk), .rst(rst), .pin(spi_sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .sys_clk(sys_clk), .rst(rst), .pin(spi_cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .sys_clk(sys_clk), .rst(rst), .pin(spi_mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic sclk_sync_unused;
  assign sclk_sync_unused = sclk_sync;

  state_e                    state_q, state_d;
  logic [FW-1:0]             shift_q, shift_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
  logic [DATAWORD_WIDTH-1:0] data_q, data_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      // Ignore any frame already under way when reset released.
      WAIT_IDLE: if (cs_sync) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        // CS release takes priority over a coincident SCLK rise.
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            cmd_d       = shift_q[FW-1 -: CMD_WIDTH];
            data_d      = shift_q[DATAWORD_WIDTH-1:0];
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FW-2:0], mosi_sync};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cmd_word  = cmd_q;
  assign data_word = data_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  // Transmit register: captures the last accepted frame at CS fall and moves
  // to the next bit on each SCLK fall so the master samples it on the rise.
  logic [FW-1:0] tx_q, tx_d;

  always_comb begin
    tx_d = tx_q;
    if (state_q == IDLE && cs_fall)
      tx_d = {cmd_q, data_q};
    else if (state_q == RECV && sclk_fall)
      tx_d = {tx_q[FW-2:0], 1'b0};
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) tx_q <= '0;
    else     tx_q <= tx_d;
  end

  assign spi_miso = (state_q == RECV) & tx_q[FW-1];
`else
  logic sclk_fall_unused;
  assign sclk_fall_unused = sclk_fall;
  assign spi_miso         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_receiver.sv
`timescale 1ns/1ps
module tb_spi_cmd_receiver;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso;
  logic [7:0]  cmd_word;
  logic [15:0] data_word;
  logic        cmd_valid, frame_err;

  spi_cmd_receiver #(.CMD_WIDTH(8), .DATAWORD_WIDTH(16), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .cmd_word(cmd_word), .data_word(data_word),
    .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  // 8 MHz system clock, 1 MHz SCLK (500 ns half period).
  always #62.5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;

  int          cyc = 0;
  int          vld_cyc = 0;
  int          err_n = 0;
  int          both_n = 0;
  logic [23:0] vq[$];

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (cmd_valid) begin
      vq.push_back({cmd_word, data_word});
      vld_cyc = cyc;
    end
    if (frame_err) err_n++;
    if (cmd_valid && frame_err) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] rx;
  int          cs_cyc;

  // Drives one frame MSB first; optional reset pulse before bit rst_at.
  // CS stays high hold_cyc system clocks afterwards.
  task automatic send_frame(input logic [31:0] bits, input int nbits,
                            input int rst_at, input int hold_cyc);
    logic [31:0] b;
    b  = bits;
    rx = '0;
    spi_cs_n = 1'b0;
    #1000;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #125;
        chk("rst_mid_cmd", cmd_word, 0);
        chk("rst_mid_data", data_word, 0);
        rst = 1'b0;
      end
      spi_mosi = b[nbits-1-i];
      #500;
      rx = {rx[30:0], spi_miso};
      spi_sclk = 1'b1;
      #500;
      spi_sclk = 1'b0;
    end
    #500;
    spi_cs_n = 1'b1;
    cs_cyc   = cyc;
    #(125 * hold_cyc);
  endtask

  int v0, e0;

  initial begin
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    #20;
    #250;
    chk("rst_cmd_word", cmd_word, 0);
    chk("rst_data_word", data_word, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_miso", spi_miso, 0);
    rst = 1'b0;
    #1250;

    // Good 24-bit frame; readback carries the reset contents (zero).
    vq.delete(); e0 = err_n;
    send_frame(32'h231234, 24, -1, 12);
    chk("f1_valid_cnt", vq.size(), 1);
    chk("f1_err_cnt", err_n - e0, 0);
    chk("f1_cmd", cmd_word, 8'h23);
    chk("f1_data", data_word, 16'h1234);
    if (vq.size() > 0) chk("f1_strobe_val", vq[0], 24'h231234);
    chk("f1_latency", vld_cyc - cs_cyc, 4);
    chk("f1_miso", rx, 0);

    // Same frame again: readback returns the previously accepted frame.
    vq.delete(); e0 = err_n;
    send_frame(32'h231234, 24, -1, 12);
    chk("f2_valid_cnt", vq.size(), 1);
    chk("f2_err_cnt", err_n - e0, 0);
`ifdef SPI_READBACK_EN
    chk("f2_miso", rx, 32'h231234);
`else
    chk("f2_miso", rx, 0);
`endif

    // Short frame: 23 bits.
    vq.delete(); e0 = err_n;
    send_frame(32'h7FFFFF, 23, -1, 12);
    chk("short_valid_cnt", vq.size(), 0);
    chk("short_err_cnt", err_n - e0, 1);
    chk("short_cmd", cmd_word, 8'h23);
    chk("short_data", data_word, 16'h1234);

    // Long frame: 25 bits.
    vq.delete(); e0 = err_n;
    send_frame(32'h0155AA55, 25, -1, 12);
    chk("long_valid_cnt", vq.size(), 0);
    chk("long_err_cnt", err_n - e0, 1);
    chk("long_cmd", cmd_word, 8'h23);
    chk("long_data", data_word, 16'h1234);

    // Reset at bit 12 with CS held low: frame must be dropped silently.
    vq.delete(); e0 = err_n;
    send_frame(32'hAAAAAA, 24, 12, 12);
    chk("rstf_valid_cnt", vq.size(), 0);
    chk("rstf_err_cnt", err_n - e0, 0);
    chk("rstf_cmd", cmd_word, 0);
    chk("rstf_data", data_word, 0);

    // Next full frame after the aborted one is accepted.
    vq.delete(); e0 = err_n;
    send_frame(32'h010FFF, 24, -1, 12);
    chk("post_valid_cnt", vq.size(), 1);
    chk("post_err_cnt", err_n - e0, 0);
    chk("post_cmd", cmd_word, 8'h01);
    chk("post_data", data_word, 16'h0FFF);
    chk("post_latency", vld_cyc - cs_cyc, 4);

    // Back-to-back frames with minimum CS high time.
    vq.delete(); e0 = err_n;
    send_frame(32'hFFFFFF, 24, -1, 2);
    send_frame(32'h000000, 24, -1, 12);
    chk("b2b_valid_cnt", vq.size(), 2);
    chk("b2b_err_cnt", err_n - e0, 0);
    if (vq.size() > 1) begin
      chk("b2b_first", vq[0], 24'hFFFFFF);
      chk("b2b_second", vq[1], 24'h000000);
    end
    chk("b2b_cmd", cmd_word, 8'h00);
    chk("b2b_data", data_word, 16'h0000);

    chk("strobes_overlap", both_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_receiver.md
# spi_cmd_receiver

SPI slave front end for the synthesizer control path. Samples the external SPI pins in the `sys_clk` domain and deserializes fixed-length frames (command byte followed by data word). Presents each complete, correctly sized frame to the command decoder as `cmd_word`/`data_word` with a one-cycle `cmd_valid` strobe. Malformed frames are discarded and flagged.

## Interface
Parameters:
- `CMD_WIDTH`, default 8: command field width in bits.
- `DATAWORD_WIDTH`, default 16: data field width in bits.
- `SYNC_STAGES`, default 2: flops in each pin synchronizer; minimum 2.

Ports:
- `sys_clk` input, 1: system clock; one clock domain. SPI pins are sampled, not used as clocks.
- `rst` input, 1: reset, asynchronous, active-high.
- `spi_sclk` input, 1: SPI clock pin. Mode 0 (CPOL=0, CPHA=0).
- `spi_cs_n` input, 1: chip select pin, active low.
- `spi_mosi` input, 1: serial data in, MSB first.
- `spi_miso` output, 1: serial data out; see Configuration.
- `cmd_word` output, `CMD_WIDTH`: command field of the last accepted frame.
- `data_word` output, `DATAWORD_WIDTH`: data field of the last accepted frame.
- `cmd_valid` output, 1: one-cycle pulse when `cmd_word`/`data_word` update.
- `frame_err` output, 1: one-cycle pulse when a frame is discarded.

## Operation
- `FRAME_WIDTH = CMD_WIDTH + DATAWORD_WIDTH`, default 24. Bit counter width is `$clog2(FRAME_WIDTH+2)`; it saturates at `FRAME_WIDTH+1`.
- Each pin passes through `SYNC_STAGES` flops. `sclk` and `cs_n` also get a 1-flop history for edge detection. This gives `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise`.
- State machine:
  - `WAIT_IDLE` (reset state): wait for synchronized `cs_n` high, then go to `IDLE`. This means a frame already in progress when reset releases is ignored.
  - `IDLE`: on `cs_fall`, clear the shift register and bit counter, then go to `RECV`.
  - `RECV`: on `sclk_rise`, shift synchronized `mosi` into the LSB and increment the counter. On `cs_rise`, go to `IDLE`:
    - if count == `FRAME_WIDTH`: load `cmd_word` (upper `CMD_WIDTH` bits) and `data_word` (lower bits) and pulse `cmd_valid`;
    - otherwise: pulse `frame_err`; `cmd_word`/`data_word` hold.
- Over-length frames (more than `FRAME_WIDTH` rises) are rejected; the counter saturates, so it never wraps to a valid count.
- If `sclk_rise` and `cs_rise` occur in the same cycle, `cs_rise` wins and the edge is not counted.
- `cmd_valid` and `frame_err` are never high together.
- Reset values: `cmd_word`=0, `data_word`=0, `cmd_valid`=0, `frame_err`=0, `spi_miso`=0, state=`WAIT_IDLE`.
- Reset mid-frame: everything returns to reset values and no strobe is issued for the aborted frame.

## Timing
- `sys_clk` must be at least 4× `spi_sclk`. SCLK high and low times must each be at least 2 `sys_clk` periods.
- CS high time between frames: at least 2 `sys_clk` periods. Back-to-back frames are then each accepted.
- Latency: `cmd_valid` goes high `SYNC_STAGES+2` `sys_clk` edges after the `spi_cs_n` pin rises. Outputs update on that same edge.
- `cmd_word`/`data_word` are stable from the `cmd_valid` cycle until the next `cmd_valid` or reset.
- Throughput: one frame per CS assertion; no backpressure. The downstream stage must accept every `cmd_valid`.

## Configuration
- `SPI_READBACK_EN` defined:
  - On `cs_fall`, a transmit shift register loads `{cmd_word, data_word}` (the last accepted frame).
  - `spi_miso` drives its MSB, and the register shifts left on each `sclk_fall` while in `RECV`.
  - First-bit setup requires the CS-fall-to-first-SCLK-rise interval to be at least `SYNC_STAGES+3` `sys_clk` periods.
  - `spi_miso` is 0 outside `RECV`.
- Not defined: `spi_miso` is tied to 0 and no transmit register is built.

## Structure
- Shared package `spi_pkg`:
  - `FRAME_WIDTH` derivation;
  - state enum `{WAIT_IDLE, IDLE, RECV}`;
  - default widths matching the command decoder parameters.
- Sub-module `spi_pin_sync`: a `SYNC_STAGES` synchronizer plus rise/fall detect. Three instances, for `sclk`, `cs_n` and `mosi`; edge outputs are unused for `mosi`.

## Test plan
- Frame `0x23`,`0x1234` (24 bits, 1 MHz SCLK, 8 MHz `sys_clk`) -> exactly one `cmd_valid`, `cmd_word`=0x23, `data_word`=0x1234, `frame_err`=0.
- 23-bit frame after the above -> one `frame_err`, no `cmd_valid`, outputs stay 0x23/0x1234.
- 25-bit frame -> one `frame_err`; outputs unchanged.
- `rst` pulsed at bit 12 and released while CS is still low -> no strobes for that frame, outputs 0; the following full frame `0x01`/`0x0FFF` is accepted.
- Two back-to-back frames `0xFF`/`0xFFFF` then `0x00`/`0x0000`, CS high for 2 `sys_clk` between them -> two `cmd_valid` pulses with matching values.
- With `SPI_READBACK_EN`, after accepting `0x23`/`0x1234` -> the next frame's MISO bits read 0x231234 MSB first.
